truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Sequencer that drives every input combination into a 4-input combinational function block (A,B,C,D -> F) and captures F for each. It compares the result against an expected truth table and reports the mismatch count and the first failing vector. It sits between a start/done control interface and the function-under-test. It replaces hand-written per-vector stimulus with a self-running hardware sweep.

Parameters:
N_IN, 4, number of function inputs; sweep covers N_VEC = 2^N_IN vectors
HOLD, 2, cycles each vector is held before F is sampled; legal range is HOLD >= 1

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  sweep request; sampled only when not busy
expected  in  N_VEC  expected F per vector; bit i is the value for vector i; latched when start is accepted
f_in  in  1  F output of the function block
abcd  out  N_IN  vector driven to the function block; MSB = A, LSB = D
busy  out  1  high while sweeping
done  out  1  high from sweep completion until the next accepted start
captured  out  N_VEC  sampled F; bit i is the value for vector i
mismatch_cnt  out  N_IN+1  count of vectors where F differs from expected (0..16)
first_err  out  N_IN  index of the lowest failing vector
err_valid  out  1  first_err is meaningful

Behaviour:
- Reset (synchronous, on rst=1 at a rising edge):
  - state=IDLE, abcd=0, busy=0, done=0, captured=0, mismatch_cnt=0, first_err=0, err_valid=0, hold count=0.
  - Reset dominates start and all other activity.
- States: IDLE, DRIVE, SAMPLE.
- IDLE, start=1:
  - Next edge: latch expected; clear captured, mismatch_cnt, err_valid, first_err, done.
  - Set abcd=0, hold count=0, busy=1, go to DRIVE.
- DRIVE:
  - abcd is stable; hold count increments each cycle.
  - When hold count == HOLD-1, go to SAMPLE.
  - abcd is therefore stable for HOLD cycles before sampling.
- SAMPLE (1 cycle):
  - captured[abcd] <= f_in.
  - If f_in != expected[abcd]: mismatch_cnt += 1; if err_valid=0, set first_err=abcd and err_valid=1.
  - If abcd == N_VEC-1: busy=0, done=1, abcd=0, go to IDLE.
  - Otherwise: abcd += 1, hold count=0, go to DRIVE.
- Timing, with the start cycle = cycle 0:
  - busy is high from cycle 1.
  - Each vector occupies HOLD+1 cycles.
  - done rises and busy falls at cycle 1 + N_VEC*(HOLD+1); this is cycle 49 for the defaults.
- start while busy is ignored, with no effect on the sweep or its timing.
- start in the same cycle that done rises is not accepted; it must be asserted once the block is in IDLE.
- done, captured, mismatch_cnt, first_err and err_valid hold their values until the next accepted start or rst.
- rst mid-sweep: all outputs return to reset values at that edge. done is not asserted, and partial results are discarded.
- Arithmetic:
  - abcd is an N_IN-bit unsigned value and never wraps within a sweep; the last vector is detected explicitly.
  - mismatch_cnt is N_IN+1 bits so the all-fail count of 16 fits without overflow.
- Output registration: all outputs are registered, and abcd changes only on SAMPLE->DRIVE transitions or at start.

Decomposition:
- Shared header/package holds:
  - N_VEC derivation (1 << N_IN)
  - state encoding constants IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2
  - default HOLD
- One sub-module, hold_counter. It takes clk, rst, clr and en, and outputs count and term (term = count == HOLD-1), with HOLD passed down as a parameter.
- The FSM, vector register and capture/compare logic stay in truth_table_sweeper.

Test Plan:
1. Defaults; f_in from a reference model of F = A&B | C&~D; expected = model table; start at cycle 0. Required: done rises at cycle 49; captured == expected; mismatch_cnt=0; err_valid=0.
2. Same setup with expected bit 5 inverted. Required: mismatch_cnt=1, first_err=5, err_valid=1, and captured still equals the model table.
3. expected = ~model table. Required: mismatch_cnt=16, first_err=0, err_valid=1.
4. rst=1 for one cycle at cycle 20 of a sweep. Required: next cycle busy=0, abcd=0, captured=0, mismatch_cnt=0, and done stays 0. A fresh start then completes at 49 cycles with correct results.
5. start pulsed at cycles 10 and 30 during a sweep. Required: ignored, done still at cycle 49; a second start after done clears done, re-sweeps, and yields identical results.
6. HOLD=1 build. Required: done at cycle 33; abcd steps 0..15 in order; each value is held exactly 2 cycles; F is sampled on the second cycle of each vector.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared constants, state encoding and width helpers for the truth-table sweeper.
package truth_table_sweeper_pkg;

  localparam int unsigned DefaultNIn  = 4;
  localparam int unsigned DefaultHold = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrive  = 2'd1,
    StSample = 2'd2
  } state_e;

  function automatic int unsigned n_vec(int unsigned n_in);
    return 1 << n_in;
  endfunction

  // At least one bit even when HOLD == 1 and the counter only ever holds zero.
  function automatic int unsigned cnt_w(int unsigned hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_hold_counter.sv
// Counts the cycles a vector has been held; term flags the last hold cycle.
module truth_table_sweeper_hold_counter
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned HOLD = DefaultHold,
  localparam int unsigned CntW = cnt_w(HOLD)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [CntW-1:0] count_o,
  output logic            term_o
);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = (count_q == CntW'(HOLD - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector into a function block, captures F and compares it to an
// expected truth table, reporting the mismatch count and the lowest failing vector.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned N_IN = DefaultNIn,
  parameter int unsigned HOLD = DefaultHold,
  localparam int unsigned NVec = n_vec(N_IN),
  localparam int unsigned CntW = cnt_w(HOLD)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [NVec-1:0] expected_i,
  input  logic            f_in_i,
  output logic [N_IN-1:0] abcd_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [NVec-1:0] captured_o,
  output logic [N_IN:0]   mismatch_cnt_o,
  output logic [N_IN-1:0] first_err_o,
  output logic            err_valid_o
);

  state_e          state_q, state_d;
  logic [N_IN-1:0] abcd_q, abcd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [NVec-1:0] captured_q, captured_d;
  logic [NVec-1:0] exp_q, exp_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] first_err_q, first_err_d;
  logic            err_valid_q, err_valid_d;

  logic            hold_clr, hold_en, hold_term;
  logic [CntW-1:0] hold_count;

  truth_table_sweeper_hold_counter #(
    .HOLD (HOLD)
  ) u_hold_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (hold_clr),
    .en_i    (hold_en),
    .count_o (hold_count),
    .term_o  (hold_term)
  );

  always_comb begin
    state_d     = state_q;
    abcd_d      = abcd_q;
    busy_d      = busy_q;
    done_d      = done_q;
    captured_d  = captured_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    first_err_d = first_err_q;
    err_valid_d = err_valid_q;
    hold_clr    = 1'b0;
    hold_en     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          exp_d       = expected_i;
          captured_d  = '0;
          cnt_d       = '0;
          first_err_d = '0;
          err_valid_d = 1'b0;
          done_d      = 1'b0;
          abcd_d      = '0;
          busy_d      = 1'b1;
          hold_clr    = 1'b1;
          state_d     = StDrive;
        end
      end
      StDrive: begin
        // Clearing on the last hold cycle leaves the counter at zero for the next vector.
        if (hold_term) begin
          hold_clr = 1'b1;
          state_d  = StSample;
        end else begin
          hold_en = 1'b1;
        end
      end
      StSample: begin
        captured_d[abcd_q] = f_in_i;
        if (f_in_i != exp_q[abcd_q]) begin
          cnt_d = cnt_q + 1'b1;
          if (!err_valid_q) begin
            first_err_d = abcd_q;
            err_valid_d = 1'b1;
          end
        end
        if (abcd_q == N_IN'(NVec - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          abcd_d  = '0;
          state_d = StIdle;
        end else begin
          abcd_d  = abcd_q + 1'b1;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      abcd_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      captured_q  <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      first_err_q <= '0;
      err_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      abcd_q      <= abcd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      captured_q  <= captured_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      first_err_q <= first_err_d;
      err_valid_q <= err_valid_d;
    end
  end

  hold_count_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
    hold_count <= CntW'(HOLD - 1));

  assign abcd_o         = abcd_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign captured_o     = captured_q;
  assign mismatch_cnt_o = cnt_q;
  assign first_err_o    = first_err_q;
  assign err_valid_o    = err_valid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with F = A&B | C&~D, default and HOLD=1 builds.
module tb_truth_table_sweeper;

  // F = A&B | C&~D is true for vectors 2,6,10,12,13,14,15.
  localparam logic [15:0] Table = 16'hF444;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start1;
  logic [15:0] expected;
  logic        f0, f1;
  logic [3:0]  abcd0, abcd1, first_err0, first_err1, prev1;
  logic        busy0, busy1, done0, done1, err_valid0, err_valid1;
  logic [15:0] captured0, captured1;
  logic [4:0]  mismatch0, mismatch1;

  int total = 0;
  int bad   = 0;
  int cyc;

  function automatic logic f_model(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & ~v[0]);
  endfunction

  assign f0 = f_model(abcd0);
  // Wrong F on the first cycle of each vector, so an early sample shows up as a bad capture.
  always @(posedge clk) prev1 <= abcd1;
  assign f1 = (abcd1 == prev1) ? f_model(abcd1) : ~f_model(abcd1);

  truth_table_sweeper dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start0),
    .expected_i     (expected),
    .f_in_i         (f0),
    .abcd_o         (abcd0),
    .busy_o         (busy0),
    .done_o         (done0),
    .captured_o     (captured0),
    .mismatch_cnt_o (mismatch0),
    .first_err_o    (first_err0),
    .err_valid_o    (err_valid0)
  );

  truth_table_sweeper #(
    .HOLD (1)
  ) dut_h1 (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start1),
    .expected_i     (expected),
    .f_in_i         (f1),
    .abcd_o         (abcd1),
    .busy_o         (busy1),
    .done_o         (done1),
    .captured_o     (captured1),
    .mismatch_cnt_o (mismatch1),
    .first_err_o    (first_err1),
    .err_valid_o    (err_valid1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Start on cycle 0, then run until done (or a cycle past rst_at when rst_at > 0).
  task automatic run0(input bit pulses, input int rst_at, output int c);
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    c = 1;
    check("busy_c1", busy0, 1);
    check("done_clr_c1", done0, 0);
    while (done0 !== 1'b1 && c < 200 && !(rst_at > 0 && c > rst_at)) begin
      start0 = pulses && (c == 10 || c == 30);
      rst    = (c == rst_at);
      @(posedge clk); #1;
      start0 = 1'b0;
      rst    = 1'b0;
      c++;
    end
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; expected = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_abcd", abcd0, 0);
    check("rst_capt", captured0, 0);
    check("rst_cnt", mismatch0, 0);
    check("rst_ferr", first_err0, 0);
    check("rst_errv", err_valid0, 0);
    rst = 1'b0;

    // 1: matching table
    expected = Table;
    run0(0, 0, cyc);
    check("t1_done_cyc", cyc, 49);
    check("t1_busy", busy0, 0);
    check("t1_abcd", abcd0, 0);
    check("t1_capt", captured0, Table);
    check("t1_cnt", mismatch0, 0);
    check("t1_errv", err_valid0, 0);

    // 2: vector 5 expectation flipped
    expected = Table ^ 16'h0020;
    run0(0, 0, cyc);
    check("t2_done_cyc", cyc, 49);
    check("t2_cnt", mismatch0, 1);
    check("t2_ferr", first_err0, 5);
    check("t2_errv", err_valid0, 1);
    check("t2_capt", captured0, Table);

    // 3: everything wrong
    expected = ~Table;
    run0(0, 0, cyc);
    check("t3_cnt", mismatch0, 16);
    check("t3_ferr", first_err0, 0);
    check("t3_errv", err_valid0, 1);

    // 4: reset mid-sweep discards partial results
    run0(0, 20, cyc);
    check("t4_cyc", cyc, 21);
    check("t4_busy", busy0, 0);
    check("t4_abcd", abcd0, 0);
    check("t4_capt", captured0, 0);
    check("t4_cnt", mismatch0, 0);
    check("t4_errv", err_valid0, 0);
    check("t4_done", done0, 0);
    repeat (60) @(posedge clk);
    #1;
    check("t4_done_idle", done0, 0);
    expected = Table;
    run0(0, 0, cyc);
    check("t4_redo_cyc", cyc, 49);
    check("t4_redo_capt", captured0, Table);
    check("t4_redo_cnt", mismatch0, 0);

    // 5: start pulses while busy are ignored; restart reproduces results
    expected = Table ^ 16'h0208;
    for (int r = 0; r < 2; r++) begin
      run0(r == 0, 0, cyc);
      check("t5_done_cyc", cyc, 49);
      check("t5_capt", captured0, Table);
      check("t5_cnt", mismatch0, 2);
      check("t5_ferr", first_err0, 3);
      check("t5_errv", err_valid0, 1);
    end

    // 6: HOLD=1 build
    expected = Table;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 200) begin
      if (cyc <= 32) check("t6_abcd", abcd1, (cyc - 1) / 2);
      @(posedge clk); #1;
      cyc++;
    end
    check("t6_done_cyc", cyc, 33);
    check("t6_busy", busy1, 0);
    check("t6_capt", captured1, Table);
    check("t6_cnt", mismatch1, 0);
    check("t6_errv", err_valid1, 0);
    check("t6_ferr", first_err1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
